// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory arbiter.
//   state_e  - arbiter FSM states (IDLE, ACCESS, DONE, ABORT)
//   grant_e  - which requester owns the current access
//   CNT_W    - width of the wait-state and data-burst counters
package mem_arb_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2,
        ABORT  = 2'd3
    } state_e;

    typedef enum logic {
        GNT_DATA  = 1'b0,
        GNT_INSTR = 1'b1
    } grant_e;

    // Word accesses only: any set byte-offset bit is a misaligned access.
    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the data port, instruction port and memory port
// of the arbiter.
//   slave  - arbiter side: takes requests and memory read data/abort,
//            drives acks, read data and the memory control signals.
//   master - environment side (core ports plus memory model).
interface mem_arbiter_if;
    // data port
    logic        i_d_rd_en;
    logic        i_d_wr_en;
    logic [31:0] i_d_address;
    logic [31:0] i_d_data;
    logic [31:0] o_d_data;
    logic        o_d_ack;
    logic        o_d_abort;
    // instruction port
    logic        i_i_req;
    logic [31:0] i_i_address;
    logic [31:0] o_i_data;
    logic        o_i_ack;
    logic        o_i_abort;
    // memory port
    logic [31:0] o_mem_address;
    logic [31:0] o_mem_data;
    logic        o_mem_rd_en;
    logic        o_mem_wr_en;
    logic [31:0] i_mem_data;
    logic        i_mem_abort;

    modport slave (
        input  i_d_rd_en, i_d_wr_en, i_d_address, i_d_data,
        input  i_i_req, i_i_address,
        input  i_mem_data, i_mem_abort,
        output o_d_data, o_d_ack, o_d_abort,
        output o_i_data, o_i_ack, o_i_abort,
        output o_mem_address, o_mem_data, o_mem_rd_en, o_mem_wr_en
    );

    modport master (
        output i_d_rd_en, i_d_wr_en, i_d_address, i_d_data,
        output i_i_req, i_i_address,
        output i_mem_data, i_mem_abort,
        input  o_d_data, o_d_ack, o_d_abort,
        input  o_i_data, o_i_ack, o_i_abort,
        input  o_mem_address, o_mem_data, o_mem_rd_en, o_mem_wr_en
    );
endinterface

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational winner select for the arbiter.
//   d_req, i_req - pending data / instruction requests
//   burst_cnt    - consecutive data grants made while a fetch was waiting
//   gnt_valid    - some request is pending
//   gnt          - winner: data unless only a fetch is pending or the data
//                  burst limit has been reached with a fetch waiting
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int MAX_DATA_BURST = 4
) (
    input  logic             d_req,
    input  logic             i_req,
    input  logic [CNT_W-1:0] burst_cnt,
    output logic             gnt_valid,
    output grant_e           gnt
);

    localparam logic [CNT_W-1:0] BURST_LIMIT = CNT_W'(MAX_DATA_BURST);

    always_comb begin
        gnt_valid = d_req | i_req;
        gnt       = GNT_DATA;
        if (i_req && (!d_req || burst_cnt == BURST_LIMIT)) begin
            gnt = GNT_INSTR;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares a single-ported 32-bit word memory between the data
// unit and the instruction fetch unit.
//   i_clk   - clock, rising edge
//   i_reset - asynchronous active-high reset
//   bus     - mem_arbiter_if.slave: data port, fetch port, memory port
// One access at a time: IDLE picks a winner and latches its request,
// ACCESS drives the memory for WAIT_STATES+1 cycles, DONE pulses the ack.
// Misaligned requests skip the memory and ack with abort through ABORT.
// Acks, read data and aborts are registered; o_mem_* decode from state.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WAIT_STATES    = 1,
    parameter int MAX_DATA_BURST = 4
) (
    input  logic          i_clk,
    input  logic          i_reset,
    mem_arbiter_if.slave  bus
);

    localparam logic [CNT_W-1:0] WAIT_LAST   = CNT_W'(WAIT_STATES);
    localparam logic [CNT_W-1:0] BURST_LIMIT = CNT_W'(MAX_DATA_BURST);

    state_e           state_reg, state_next;
    logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic [CNT_W-1:0] burst_cnt_reg, burst_cnt_next;
    grant_e           gnt_reg, gnt_next;
    logic [31:0]      addr_reg, addr_next;
    logic [31:0]      wdata_reg, wdata_next;
    logic             write_reg, write_next;
    logic             d_ack_reg, d_ack_next;
    logic             d_abort_reg, d_abort_next;
    logic [31:0]      d_data_reg, d_data_next;
    logic             i_ack_reg, i_ack_next;
    logic             i_abort_reg, i_abort_next;
    logic [31:0]      i_data_reg, i_data_next;

    logic        d_req;
    logic        pick_valid;
    grant_e      pick_gnt;
    logic [31:0] sel_addr;
    logic        in_access;
    logic        access_last;

    assign d_req    = bus.i_d_rd_en | bus.i_d_wr_en;
    assign sel_addr = (pick_gnt == GNT_DATA) ? bus.i_d_address : bus.i_i_address;

    mem_arb_pick #(
        .MAX_DATA_BURST (MAX_DATA_BURST)
    ) u_pick (
        .d_req     (d_req),
        .i_req     (bus.i_i_req),
        .burst_cnt (burst_cnt_reg),
        .gnt_valid (pick_valid),
        .gnt       (pick_gnt)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_reg     <= IDLE;
            wait_cnt_reg  <= '0;
            burst_cnt_reg <= '0;
            gnt_reg       <= GNT_DATA;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            write_reg     <= 1'b0;
            d_ack_reg     <= 1'b0;
            d_abort_reg   <= 1'b0;
            d_data_reg    <= '0;
            i_ack_reg     <= 1'b0;
            i_abort_reg   <= 1'b0;
            i_data_reg    <= '0;
        end else begin
            state_reg     <= state_next;
            wait_cnt_reg  <= wait_cnt_next;
            burst_cnt_reg <= burst_cnt_next;
            gnt_reg       <= gnt_next;
            addr_reg      <= addr_next;
            wdata_reg     <= wdata_next;
            write_reg     <= write_next;
            d_ack_reg     <= d_ack_next;
            d_abort_reg   <= d_abort_next;
            d_data_reg    <= d_data_next;
            i_ack_reg     <= i_ack_next;
            i_abort_reg   <= i_abort_next;
            i_data_reg    <= i_data_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        wait_cnt_next  = wait_cnt_reg;
        burst_cnt_next = burst_cnt_reg;
        gnt_next       = gnt_reg;
        addr_next      = addr_reg;
        wdata_next     = wdata_reg;
        write_next     = write_reg;
        // response registers are single-cycle pulses: cleared unless loaded
        d_ack_next     = 1'b0;
        d_abort_next   = 1'b0;
        d_data_next    = '0;
        i_ack_next     = 1'b0;
        i_abort_next   = 1'b0;
        i_data_next    = '0;

        case (state_reg)
            IDLE: begin
                if (!bus.i_i_req) begin
                    burst_cnt_next = '0;
                end
                if (pick_valid) begin
                    gnt_next      = pick_gnt;
                    addr_next     = sel_addr;
                    wdata_next    = bus.i_d_data;
                    write_next    = (pick_gnt == GNT_DATA) && bus.i_d_wr_en;
                    wait_cnt_next = '0;
                    if (pick_gnt == GNT_INSTR) begin
                        burst_cnt_next = '0;
                    end else if (bus.i_i_req && burst_cnt_reg != BURST_LIMIT) begin
                        burst_cnt_next = burst_cnt_reg + CNT_W'(1);
                    end
                    if (is_misaligned(sel_addr)) begin
                        // ack with abort straight away; memory is never touched
                        state_next = ABORT;
                        if (pick_gnt == GNT_DATA) begin
                            d_ack_next   = 1'b1;
                            d_abort_next = 1'b1;
                        end else begin
                            i_ack_next   = 1'b1;
                            i_abort_next = 1'b1;
                        end
                    end else begin
                        state_next = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (wait_cnt_reg == WAIT_LAST) begin
                    state_next = DONE;
                    if (gnt_reg == GNT_DATA) begin
                        d_ack_next   = 1'b1;
                        d_abort_next = bus.i_mem_abort;
                        d_data_next  = write_reg ? 32'h0 : bus.i_mem_data;
                    end else begin
                        i_ack_next   = 1'b1;
                        i_abort_next = bus.i_mem_abort;
                        i_data_next  = bus.i_mem_data;
                    end
                end else begin
                    wait_cnt_next = wait_cnt_reg + CNT_W'(1);
                end
            end
            DONE, ABORT: begin
                // requests are not sampled here so the requester can react to the ack
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign in_access   = (state_reg == ACCESS);
    assign access_last = in_access && (wait_cnt_reg == WAIT_LAST);

    assign bus.o_mem_address = in_access ? addr_reg : 32'h0;
    assign bus.o_mem_data    = (in_access && write_reg) ? wdata_reg : 32'h0;
    assign bus.o_mem_rd_en   = in_access && !write_reg;
    // single write strobe on the last cycle, once address/data have been stable
    assign bus.o_mem_wr_en   = access_last && write_reg;

    assign bus.o_d_ack   = d_ack_reg;
    assign bus.o_d_abort = d_abort_reg;
    assign bus.o_d_data  = d_data_reg;
    assign bus.o_i_ack   = i_ack_reg;
    assign bus.o_i_abort = i_abort_reg;
    assign bus.o_i_data  = i_data_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter.
// dut_a (WAIT_STATES=1, MAX_DATA_BURST=4) is checked every cycle against a
// transaction-level schedule model; dut_b (WAIT_STATES=2) covers reset
// during a write. Directed scenarios add literal expectations.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int WS_A  = 1;
    localparam int MAX_A = 4;
    localparam int WS_B  = 2;

    logic clk   = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if if_a ();
    mem_arbiter_if if_b ();

    mem_arbiter #(.WAIT_STATES(WS_A), .MAX_DATA_BURST(MAX_A)) dut_a (
        .i_clk   (clk),
        .i_reset (rst_a),
        .bus     (if_a.slave)
    );

    mem_arbiter #(.WAIT_STATES(WS_B), .MAX_DATA_BURST(MAX_A)) dut_b (
        .i_clk   (clk),
        .i_reset (rst_b),
        .bus     (if_b.slave)
    );

    // ---------------- memory models ----------------
    bit [31:0] mem_a [0:1023];
    bit [31:0] mem_b [0:1023];
    bit [31:0] model_mem [0:1023];
    logic        pre_a_en = 1'b0, pre_b_en = 1'b0;
    logic [31:0] pre_a_addr = '0, pre_a_data = '0, pre_b_addr = '0, pre_b_data = '0;

    function automatic logic abort_f(input logic [31:0] a);
        return a[11:5] == 7'b0000111;   // words 0xE0..0xFF abort
    endfunction

    always @(posedge clk) begin
        if (if_a.o_mem_wr_en) mem_a[if_a.o_mem_address[11:2]] <= if_a.o_mem_data;
        else if (pre_a_en)    mem_a[pre_a_addr[11:2]]         <= pre_a_data;
        if (if_b.o_mem_wr_en) mem_b[if_b.o_mem_address[11:2]] <= if_b.o_mem_data;
        else if (pre_b_en)    mem_b[pre_b_addr[11:2]]         <= pre_b_data;
    end
    assign if_a.i_mem_data  = mem_a[if_a.o_mem_address[11:2]];
    assign if_a.i_mem_abort = abort_f(if_a.o_mem_address);
    assign if_b.i_mem_data  = mem_b[if_b.o_mem_address[11:2]];
    assign if_b.i_mem_abort = abort_f(if_b.o_mem_address);

    // ---------------- bookkeeping ----------------
    int total = 0;
    int bad = 0;
    int cycle_no = 0;
    int b_wr_total = 0;
    int b_ack_total = 0;

    always @(negedge clk) begin
        if (if_b.o_mem_wr_en) b_wr_total++;
        if (if_b.o_d_ack || if_b.o_i_ack) b_ack_total++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // ---------------- transaction-level model of dut_a ----------------
    logic [31:0] exp_d_data = '0, exp_i_data = '0, exp_mem_address = '0, exp_mem_data = '0;
    logic exp_d_ack = 0, exp_d_abort = 0, exp_i_ack = 0, exp_i_abort = 0;
    logic exp_mem_rd_en = 0, exp_mem_wr_en = 0;

    bit          m_busy = 0;
    bit          m_instr, m_write, m_mis, m_abort;
    int          m_g, m_ack_at, m_free_at, m_burst = 0;
    logic [31:0] m_addr, m_wdata, m_rdata;
    int          model_acks = 0;

    task automatic model_eval();
        bit dreq, ireq, grant;
        exp_d_data = '0; exp_i_data = '0; exp_mem_address = '0; exp_mem_data = '0;
        exp_d_ack = 0; exp_d_abort = 0; exp_i_ack = 0; exp_i_abort = 0;
        exp_mem_rd_en = 0; exp_mem_wr_en = 0;
        if (rst_a) begin
            m_busy = 0; m_burst = 0;
            return;
        end
        if (m_busy && cycle_no >= m_free_at) m_busy = 0;
        if (!m_busy) begin
            dreq = if_a.i_d_rd_en || if_a.i_d_wr_en;
            ireq = if_a.i_i_req;
            grant = 0;
            if (!ireq) m_burst = 0;
            if (dreq && !(ireq && m_burst == MAX_A)) begin
                grant = 1; m_instr = 0;
                m_addr = if_a.i_d_address; m_wdata = if_a.i_d_data; m_write = if_a.i_d_wr_en;
                if (ireq && m_burst < MAX_A) m_burst++;
            end else if (ireq) begin
                grant = 1; m_instr = 1;
                m_addr = if_a.i_i_address; m_wdata = '0; m_write = 0;
                m_burst = 0;
            end
            if (grant) begin
                m_busy = 1; m_g = cycle_no;
                m_mis = (m_addr % 4) != 0;
                m_ack_at = m_mis ? m_g + 1 : m_g + 2 + WS_A;
                m_free_at = m_ack_at + 1;
                if (!m_mis) begin
                    m_abort = abort_f(m_addr);
                    if (m_write) model_mem[m_addr[11:2]] = m_wdata;
                    else         m_rdata = model_mem[m_addr[11:2]];
                end
            end
        end
        if (m_busy) begin
            if (!m_mis && cycle_no >= m_g + 1 && cycle_no <= m_g + 1 + WS_A) begin
                exp_mem_address = m_addr;
                exp_mem_rd_en   = !m_write;
                exp_mem_wr_en   = m_write && cycle_no == m_g + 1 + WS_A;
                exp_mem_data    = m_write ? m_wdata : 32'h0;
            end
            if (cycle_no == m_ack_at) begin
                model_acks++;
                if (!m_instr) begin
                    exp_d_ack   = 1;
                    exp_d_abort = m_mis ? 1'b1 : m_abort;
                    exp_d_data  = (m_mis || m_write) ? 32'h0 : m_rdata;
                end else begin
                    exp_i_ack   = 1;
                    exp_i_abort = m_mis ? 1'b1 : m_abort;
                    exp_i_data  = m_mis ? 32'h0 : m_rdata;
                end
            end
        end
    endtask

    // one compare per cycle of every dut_a output against the model
    always @(negedge clk) begin
        total++;
        if ({if_a.o_d_ack, if_a.o_d_abort, if_a.o_d_data, if_a.o_i_ack, if_a.o_i_abort, if_a.o_i_data,
             if_a.o_mem_rd_en, if_a.o_mem_wr_en, if_a.o_mem_address, if_a.o_mem_data} !==
            {exp_d_ack, exp_d_abort, exp_d_data, exp_i_ack, exp_i_abort, exp_i_data,
             exp_mem_rd_en, exp_mem_wr_en, exp_mem_address, exp_mem_data}) begin
            bad++;
            $display("FAIL cmp cycle %0d: got dack=%b dab=%b dd=%h iack=%b iab=%b id=%h rd=%b wr=%b ad=%h wd=%h want dack=%b dab=%b dd=%h iack=%b iab=%b id=%h rd=%b wr=%b ad=%h wd=%h",
                     cycle_no, if_a.o_d_ack, if_a.o_d_abort, if_a.o_d_data, if_a.o_i_ack, if_a.o_i_abort,
                     if_a.o_i_data, if_a.o_mem_rd_en, if_a.o_mem_wr_en, if_a.o_mem_address, if_a.o_mem_data,
                     exp_d_ack, exp_d_abort, exp_d_data, exp_i_ack, exp_i_abort, exp_i_data,
                     exp_mem_rd_en, exp_mem_wr_en, exp_mem_address, exp_mem_data);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
        cycle_no++;
    endtask

    task automatic settle();
        model_eval();
        #3;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            next_cycle();
            settle();
        end
    endtask

    task automatic zero_inputs();
        if_a.i_d_rd_en = 0; if_a.i_d_wr_en = 0; if_a.i_d_address = '0; if_a.i_d_data = '0;
        if_a.i_i_req = 0; if_a.i_i_address = '0;
        if_b.i_d_rd_en = 0; if_b.i_d_wr_en = 0; if_b.i_d_address = '0; if_b.i_d_data = '0;
        if_b.i_i_req = 0; if_b.i_i_address = '0;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = 32'($urandom_range(0, 63)) * 4;
        if ($urandom_range(0, 9) == 0) a = a + 32'($urandom_range(1, 3));
        return a;
    endfunction

    bit d_act = 0, i_act = 0;

    task automatic rand_reqs();
        int k;
        int ipct;
        if (exp_d_ack) d_act = 0;
        if (exp_i_ack) i_act = 0;
        if (!d_act && $urandom_range(0, 99) < 55) begin
            d_act = 1;
            k = $urandom_range(0, 2);
            if_a.i_d_rd_en = (k != 1);
            if_a.i_d_wr_en = (k != 0);
            if_a.i_d_address = rand_addr();
            if_a.i_d_data = $urandom;
        end else if (!d_act) begin
            if_a.i_d_rd_en = 0; if_a.i_d_wr_en = 0;
            if_a.i_d_address = $urandom; if_a.i_d_data = $urandom;
        end
        ipct = ((cycle_no % 200) < 100) ? 90 : 30;
        if (!i_act && $urandom_range(0, 99) < ipct) begin
            i_act = 1;
            if_a.i_i_req = 1;
            if_a.i_i_address = rand_addr();
        end else if (!i_act) begin
            if_a.i_i_req = 0;
            if_a.i_i_address = $urandom;
        end
    endtask

    // ---------------- main sequence ----------------
    int seq [0:7];
    int n_seq, wr_cnt, wr_cyc, dack_cyc, iack_cyc, rd_cyc_cnt, mm;
    logic [31:0] idata, bdata;
    bit prev_d, prev_i;

    initial begin
        zero_inputs();

        // reset with random inputs; memories preloaded meanwhile
        for (int i = 0; i < 8; i++) begin
            next_cycle();
            if_a.i_d_rd_en = 1'($urandom_range(0, 1)); if_a.i_d_wr_en = 1'($urandom_range(0, 1));
            if_a.i_d_address = $urandom; if_a.i_d_data = $urandom;
            if_a.i_i_req = 1'($urandom_range(0, 1)); if_a.i_i_address = $urandom;
            if_b.i_d_rd_en = 1'($urandom_range(0, 1)); if_b.i_d_wr_en = 1'($urandom_range(0, 1));
            if_b.i_d_address = $urandom; if_b.i_i_req = 1'($urandom_range(0, 1));
            pre_a_en = (i == 0); pre_a_addr = 32'h100; pre_a_data = 32'hDEADBEEF;
            pre_b_en = (i == 0); pre_b_addr = 32'h300; pre_b_data = 32'hAAAAAAAA;
            if (i == 0) model_mem[32'h100 >> 2] = 32'hDEADBEEF;
            settle();
        end
        chk("rst_state_a", 32'(dut_a.state_reg), 32'(IDLE));
        chk("rst_state_b", 32'(dut_b.state_reg), 32'(IDLE));
        chk("rst_b_outs", {if_b.o_d_ack, if_b.o_i_ack, if_b.o_mem_rd_en, if_b.o_mem_wr_en},
            32'h0);
        chk("rst_b_addr", if_b.o_mem_address, 32'h0);

        next_cycle();
        zero_inputs();
        rst_a = 0; rst_b = 0;
        settle();
        idle_cycles(2);

        // single read at 0x100
        next_cycle(); if_a.i_d_rd_en = 1; if_a.i_d_address = 32'h100; settle();
        chk("rd_c0_rden", 32'(if_a.o_mem_rd_en), 32'h0);
        for (int c = 1; c <= 3; c++) begin
            next_cycle(); settle();
            if (c < 3) chk($sformatf("rd_c%0d_rden", c), 32'(if_a.o_mem_rd_en), 32'h1);
            else begin
                chk("rd_c3_dack", 32'(if_a.o_d_ack), 32'h1);
                chk("rd_c3_ddata", if_a.o_d_data, 32'hDEADBEEF);
                chk("rd_c3_iack", 32'(if_a.o_i_ack), 32'h0);
            end
        end
        next_cycle(); if_a.i_d_rd_en = 0; settle();
        idle_cycles(2);

        // contention: write 0x200 vs fetch 0x200
        next_cycle();
        if_a.i_d_wr_en = 1; if_a.i_d_address = 32'h200; if_a.i_d_data = 32'h12345678;
        if_a.i_i_req = 1; if_a.i_i_address = 32'h200;
        settle();
        wr_cnt = 0; wr_cyc = -1; dack_cyc = -1; iack_cyc = -1; idata = '0;
        for (int c = 1; c <= 7; c++) begin
            next_cycle();
            if (c == 4) if_a.i_d_wr_en = 0;
            settle();
            if (if_a.o_mem_wr_en) begin wr_cnt++; wr_cyc = c; end
            if (if_a.o_d_ack) dack_cyc = c;
            if (if_a.o_i_ack) begin iack_cyc = c; idata = if_a.o_i_data; end
            if (c == 5) chk("cont_c5_fetch_addr", {if_a.o_mem_address[31:1], if_a.o_mem_rd_en}, 32'h201);
        end
        next_cycle(); if_a.i_i_req = 0; settle();
        chk("cont_wr_pulses", 32'(wr_cnt), 32'd1);
        chk("cont_wr_cycle", 32'(wr_cyc), 32'd2);
        chk("cont_dack_cycle", 32'(dack_cyc), 32'd3);
        chk("cont_iack_cycle", 32'(iack_cyc), 32'd7);
        chk("cont_idata", idata, 32'h12345678);
        idle_cycles(2);

        // misaligned read
        next_cycle(); if_a.i_d_rd_en = 1; if_a.i_d_address = 32'h102; settle();
        chk("mis_c0_en", {if_a.o_mem_rd_en, if_a.o_mem_wr_en}, 32'h0);
        next_cycle(); settle();
        chk("mis_c1_ack_abort", {if_a.o_d_ack, if_a.o_d_abort, if_a.o_mem_rd_en, if_a.o_mem_wr_en}, 32'hC);
        chk("mis_c1_data", if_a.o_d_data, 32'h0);
        next_cycle(); if_a.i_d_rd_en = 0; settle();
        chk("mis_c2_en", {if_a.o_mem_rd_en, if_a.o_mem_wr_en}, 32'h0);
        idle_cycles(2);

        // starvation: back-to-back data with a fetch held pending
        n_seq = 0; prev_d = 0; prev_i = 0;
        next_cycle();
        if_a.i_d_rd_en = 1; if_a.i_d_address = 32'h80;
        if_a.i_i_req = 1; if_a.i_i_address = 32'h40;
        settle();
        for (int c = 0; c < 80 && n_seq < 6; c++) begin
            next_cycle();
            if (prev_d) if_a.i_d_address = 32'h80 + 32'(4 * (n_seq % 8));
            if (prev_i) if_a.i_i_address = if_a.i_i_address + 32'h4;
            settle();
            prev_d = if_a.o_d_ack; prev_i = if_a.o_i_ack;
            if (prev_d) begin seq[n_seq] = 0; n_seq++; end
            if (prev_i) begin seq[n_seq] = 1; n_seq++; end
        end
        next_cycle(); if_a.i_d_rd_en = 0; if_a.i_i_req = 0; settle();
        chk("starve_acks", 32'(n_seq), 32'd6);
        for (int k = 0; k < 6; k++)
            chk($sformatf("starve_seq%0d", k), 32'(seq[k]), (k == 4) ? 32'd1 : 32'd0);
        idle_cycles(2);

        // dut_b: reset during the first ACCESS cycle of a write
        next_cycle();
        if_b.i_d_wr_en = 1; if_b.i_d_address = 32'h300; if_b.i_d_data = 32'h55555555;
        settle();
        next_cycle(); settle();
        chk("rstw_c1_access", {if_b.o_mem_address[31:1], if_b.o_mem_wr_en}, 32'h300);
        rst_b = 1;
        #1;
        chk("rstw_async_outs", {if_b.o_mem_wr_en, if_b.o_mem_rd_en, if_b.o_d_ack, if_b.o_i_ack}, 32'h0);
        chk("rstw_async_addr", if_b.o_mem_address, 32'h0);
        next_cycle(); if_b.i_d_wr_en = 0; rst_b = 0; settle();
        idle_cycles(8);
        chk("rstw_no_wr", 32'(b_wr_total), 32'd0);
        chk("rstw_no_ack", 32'(b_ack_total), 32'd0);
        chk("rstw_mem", mem_b[32'h300 >> 2], 32'hAAAAAAAA);

        // read back through dut_b (WAIT_STATES=2: ack in cycle 4)
        next_cycle(); if_b.i_d_rd_en = 1; if_b.i_d_address = 32'h300; settle();
        dack_cyc = -1; bdata = '0; rd_cyc_cnt = 0;
        for (int c = 1; c <= 6; c++) begin
            next_cycle();
            if (c == 5) if_b.i_d_rd_en = 0;
            settle();
            if (if_b.o_mem_rd_en) rd_cyc_cnt++;
            if (if_b.o_d_ack) begin dack_cyc = c; bdata = if_b.o_d_data; end
        end
        chk("b_rd_cycles", 32'(rd_cyc_cnt), 32'd3);
        chk("b_ack_cycle", 32'(dack_cyc), 32'd4);
        chk("b_rd_data", bdata, 32'hAAAAAAAA);

        // randomized traffic on dut_a against the model
        model_acks = 0;
        for (int i = 0; i < 3000; i++) begin
            next_cycle();
            rand_reqs();
            settle();
        end
        next_cycle(); zero_inputs(); settle();
        idle_cycles(10);
        chk("rand_ack_activity", 32'(model_acks > 400), 32'd1);

        mm = 0;
        for (int w = 0; w < 1024; w++) if (mem_a[w] !== model_mem[w]) mm++;
        chk("mem_final", 32'(mm), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequences a single-ported 32-bit word memory between the core's data unit and instruction fetch unit. Each requester holds a request until a one-cycle ack; the arbiter grants one access at a time, inserts programmable wait states, and forwards read data and aborts. Data has priority, with a burst limit that stops instruction fetch from starving. It sits between the core's memory ports and the memory model.

## Interface
- `WAIT_STATES`, default 1: extra cycles the memory needs per access (0..15).
- `MAX_DATA_BURST`, default 4: maximum consecutive data grants while an instruction request is pending (1..15).
- `i_clk` in 1: clock, rising edge.
- `i_reset` in 1: asynchronous, active-high reset.
- `i_d_rd_en` in 1: data read request.
- `i_d_wr_en` in 1: data write request; wins over `i_d_rd_en` if both are high.
- `i_d_address` in 32: data byte address.
- `i_d_data` in 32: data write value.
- `o_d_data` out 32: data read value, valid while `o_d_ack`.
- `o_d_ack` out 1: one-cycle data completion pulse.
- `o_d_abort` out 1: data abort, valid while `o_d_ack`.
- `i_i_req` in 1: instruction fetch request.
- `i_i_address` in 32: fetch byte address.
- `o_i_data` out 32: fetched word, valid while `o_i_ack`.
- `o_i_ack` out 1: one-cycle fetch completion pulse.
- `o_i_abort` out 1: instruction abort, valid while `o_i_ack`.
- `o_mem_address` out 32: memory address.
- `o_mem_data` out 32: memory write data.
- `o_mem_rd_en` out 1: memory read enable.
- `o_mem_wr_en` out 1: memory write enable; the memory writes on the rising edge.
- `i_mem_data` in 32: combinational memory read data.
- `i_mem_abort` in 1: memory abort, sampled on the last access cycle.

## Operation
- FSM states:
  - IDLE: samples requests.
  - ACCESS: drives the memory, with a wait counter running from 0 to `WAIT_STATES`.
  - DONE: drives the ack.
  - ABORT: ack with abort, no memory access.
- Pick in IDLE:
  - Data only: data wins.
  - Instruction only: instruction wins.
  - Both pending: data wins unless `burst_cnt == MAX_DATA_BURST`, in which case instruction wins.
- `burst_cnt`:
  - Increments on a data grant made while `i_i_req` is high.
  - Clears on an instruction grant, or in IDLE when `i_i_req` is low.
  - Saturates at `MAX_DATA_BURST`.
- The winner's address, data and direction are latched at grant. Requester inputs are ignored after grant.
- Misalignment: if the granted address has `[1:0] != 0`, go to ABORT. No memory enable is asserted; the ack carries abort=1 and data=0.
- ACCESS, all cycles:
  - `o_mem_address` is driven from the latched address and held stable.
  - For a read, `o_mem_rd_en` is high on every ACCESS cycle.
- ACCESS, last cycle (counter == `WAIT_STATES`):
  - For a write, `o_mem_wr_en` is high on this cycle only. Exactly one write pulse is issued per write access.
  - `i_mem_data` and `i_mem_abort` are registered into the response registers, then the FSM goes to DONE.
- DONE and ABORT:
  - Pulse the granted port's ack for one cycle, with its data and abort.
  - The ungranted port's ack stays 0.
  - Next state is IDLE.
  - Requests are not sampled in these states. A requester therefore updates or drops its request in the cycle after the ack, and nothing is serviced twice.
- Write ack data: `o_d_data` = 0.
- Outputs not in use are 0: memory enables outside ACCESS, and `o_*_data` and `o_*_abort` when there is no ack.
- Reset asserted at any time:
  - FSM goes to IDLE and `burst_cnt` to 0; all outputs go to 0 immediately.
  - A write abandoned before its last ACCESS cycle never pulses `o_mem_wr_en`.

## Timing
- Request high in cycle 0 while IDLE:
  - ACCESS occupies cycles 1 to 1+`WAIT_STATES`.
  - Ack is in cycle 2+`WAIT_STATES` (cycle 3 at the default).
  - The next IDLE sample is in cycle 3+`WAIT_STATES`.
- Misaligned request: ABORT ack in cycle 1.
- Throughput: one access per `WAIT_STATES`+3 cycles.
- Outputs are registered, except `o_mem_*`, which decode from the state and latched registers.

## Structure
- Package `mem_arb_pkg`:
  - State encoding: IDLE, ACCESS, DONE, ABORT.
  - Grant encoding: GNT_DATA, GNT_INSTR.
  - Width constant for the wait and burst counters (4 bits).
- Sub-module `mem_arb_pick`: combinational winner select from the two requests, `burst_cnt` and `MAX_DATA_BURST`. Everything else is inline.

## Test plan
- Reset: drive random inputs with `i_reset` high. All outputs must be 0 and the FSM in IDLE.
- Single read, `WAIT_STATES`=1: memory word 0x100 = 0xDEADBEEF; read request at 0x100 in cycle 0. Required: `o_mem_rd_en` high in cycles 1–2, `o_d_ack` high in cycle 3 with `o_d_data`=0xDEADBEEF, and no `o_i_ack`.
- Contention: data write of 0x12345678 to 0x200 and instruction fetch of 0x200, both raised in cycle 0. Required:
  - Exactly one `o_mem_wr_en` pulse, in cycle 2.
  - `o_d_ack` in cycle 3.
  - Fetch granted in cycle 4, with `o_i_ack` in cycle 7 and `o_i_data`=0x12345678.
- Starvation: data requests back-to-back with `i_i_req` held high. Required: after 4 data acks the next grant is the instruction fetch; afterwards data wins again.
- Misaligned: data read at 0x102. Required: `o_d_ack`=1 and `o_d_abort`=1 in cycle 1, memory enables never high.
- Reset mid-write: a write to 0x300 (prior contents 0xAAAAAAAA) is in the first ACCESS cycle, with `WAIT_STATES`=2, when `i_reset` pulses. Required: no `o_mem_wr_en`, 0x300 still reads 0xAAAAAAAA, and no ack.
